// File: rtl/gate_mux_unit.sv
// gate_mux_unit: registered bitwise AND, NOT and 2:1 mux of two operands, one-cycle latency.
// Define GATE_MUX_UNIT_CNT_EN to add the 16-bit wrapping result_cnt output.
module gate_mux_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_not,
  output logic [WIDTH-1:0] y_mux
`ifdef GATE_MUX_UNIT_CNT_EN
  ,
  output logic [15:0]      result_cnt
`endif
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] and_q, and_d, not_q, not_d, mux_q, mux_d;
  always_comb begin
    valid_d = in_valid;
    and_d   = in_valid ? (a & b) : and_q;
    not_d   = in_valid ? ~a : not_q;
    mux_d   = in_valid ? (sel ? b : a) : mux_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      and_q   <= '0;
      not_q   <= '0;
      mux_q   <= '0;
    end else begin
      valid_q <= valid_d;
      and_q   <= and_d;
      not_q   <= not_d;
      mux_q   <= mux_d;
    end
  end
  assign out_valid = valid_q;
  assign y_and     = and_q;
  assign y_not     = not_q;
  assign y_mux     = mux_q;
`ifdef GATE_MUX_UNIT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + 16'(in_valid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign result_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_gate_mux_unit.sv
// tb_gate_mux_unit: scoreboard bench for gate_mux_unit (WIDTH=8); driver queues expected results, monitor checks them.
module tb_gate_mux_unit;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] y_and;
    logic [W-1:0] y_not;
    logic [W-1:0] y_mux;
  } res_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         sel = 1'b0;
  logic         out_valid;
  logic [W-1:0] y_and, y_not, y_mux;
`ifdef GATE_MUX_UNIT_CNT_EN
  logic [15:0]  result_cnt;
`endif
  res_t         q[$];
  res_t         last_exp = '0;
  logic [15:0]  n_push = '0;
  int           tests = 0;
  int           fails = 0;
  gate_mux_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .y_and(y_and), .y_not(y_not), .y_mux(y_mux)
`ifdef GATE_MUX_UNIT_CNT_EN
    , .result_cnt(result_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic void check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction
  // Expected results follow straight from the operator definitions.
  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    @(negedge clk);
    in_valid = v;
    a = ta;
    b = tb_;
    sel = ts;
    if (v) begin
      q.push_back(res_t'{ta & tb_, ~ta, ts ? tb_ : ta});
      n_push++;
    end
  endtask
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    last_exp = '0;
    n_push = '0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y_and", {56'd0, y_and}, 64'd0);
    check("rst_y_not", {56'd0, y_not}, 64'd0);
    check("rst_y_mux", {56'd0, y_mux}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  always begin
    @(posedge clk);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) last_exp = q.pop_front();
    check("y_and", {56'd0, y_and}, {56'd0, last_exp.y_and});
    check("y_not", {56'd0, y_not}, {56'd0, last_exp.y_not});
    check("y_mux", {56'd0, y_mux}, {56'd0, last_exp.y_mux});
`ifdef GATE_MUX_UNIT_CNT_EN
    check("result_cnt", {48'd0, result_cnt}, {48'd0, n_push});
`endif
  end
  initial begin
    #3;
    check("init_out_valid", {63'd0, out_valid}, 64'd0);
    check("init_y_not", {56'd0, y_not}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h00, 8'h00, 0);
    drive(1, 8'h00, 8'h01, 0);
    drive(1, 8'h01, 8'h00, 1);
    drive(1, 8'h01, 8'h01, 1);
    for (int i = 0; i < 3; i++) drive(0, W'($urandom), W'($urandom), 1'($urandom));
    drive(1, 8'hF0, 8'h3C, 0);
    drive(1, 8'hF0, 8'h3C, 1);
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
    drive(1, 8'hFF, 8'hFF, 1);
    mid_reset();
    drive(1, 8'hA5, 8'h5A, 1);
    drive(1, 8'h3C, 8'hF0, 0);
    for (int i = 0; i < 100; i++)
      drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
`ifdef GATE_MUX_UNIT_CNT_EN
    mid_reset();
    for (int i = 0; i < 65537; i++) drive(1, W'($urandom), W'($urandom), 1'($urandom));
    drive(0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #2;
    check("cnt_wrap", {48'd0, result_cnt}, 64'd1);
`endif
    drive(0, 8'h55, 8'hAA, 0);
    drive(0, 8'hAA, 8'h55, 1);
    @(posedge clk);
    #2;
    check("drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gate_mux_unit.md
GATE_MUX_UNIT -- requirements
Module: gate_mux_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of data operands and results (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, qualifying a, b and sel for capture.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port sel, input, 1 bit, mux select applied to all bits.
REQ-008 The block SHALL have port out_valid, output, 1 bit, high for one cycle when new results are presented.
REQ-009 The block SHALL have port y_and, output, WIDTH bits, registered bitwise a AND b.
REQ-010 The block SHALL have port y_not, output, WIDTH bits, registered bitwise NOT a.
REQ-011 The block SHALL have port y_mux, output, WIDTH bits, registered mux result: a when sel=0, b when sel=1.

Function
REQ-012 On a rising clk edge with in_valid=1, y_and, y_not and y_mux SHALL all load results computed from the a, b and sel values sampled at that edge, giving a latency of exactly 1 cycle.
REQ-013 On a rising clk edge with in_valid=1, out_valid SHALL be set to 1.
REQ-014 On a rising clk edge with in_valid=0, y_and, y_not and y_mux SHALL hold their previous values.
REQ-015 On a rising clk edge with in_valid=0, out_valid SHALL be set to 0.
REQ-016 Back-to-back in_valid=1 cycles SHALL produce a result every cycle with no bubbles.
REQ-017 The block SHALL have no back-pressure.
REQ-018 Each result bit i SHALL depend only on bit i of a and b and on sel, with no cross-bit carries.
REQ-019 If sel is X or Z while in_valid=1, behaviour is undefined; no recovery logic is required.
REQ-020 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-021 While rst_n=0, out_valid, y_and, y_not and y_mux SHALL be 0 immediately, independent of clk.
REQ-022 y_not SHALL reset to 0 (not to the inversion of a).
REQ-023 After rst_n is deasserted, the first rising clk edge with in_valid=1 SHALL load results normally.
REQ-024 Reset asserted mid-stream SHALL discard any in-flight result.

Configuration
REQ-025 Macro GATE_MUX_UNIT_CNT_EN, when defined, SHALL add output result_cnt, 16 bits, which increments by 1 on each rising clk edge with in_valid=1.
REQ-026 When GATE_MUX_UNIT_CNT_EN is defined, result_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-027 When GATE_MUX_UNIT_CNT_EN is defined, result_cnt SHALL reset asynchronously to 0 when rst_n=0.
REQ-028 When GATE_MUX_UNIT_CNT_EN is undefined, port result_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=1, a=0 b=0 sel=0 with in_valid=1 -> after one edge: y_and=0, y_not=1, y_mux=0, out_valid=1.
REQ-030 WIDTH=1, sequence a/b/sel = 0/1/0, 1/0/1, 1/1/1 on consecutive in_valid=1 cycles -> results one cycle later: (y_and,y_not,y_mux) = (0,1,0), (0,0,0), (1,0,1).
REQ-031 After a result is loaded, drop in_valid and toggle a and b for 3 cycles -> outputs hold, out_valid=0.
REQ-032 WIDTH=8, a=0xF0, b=0x3C: sel=0 -> y_and=0x30, y_not=0x0F, y_mux=0xF0; sel=1 -> y_mux=0x3C.
REQ-033 Assert rst_n=0 between clk edges during streaming -> all outputs become 0 without waiting for a clk edge; the first valid input after release gives the correct result one cycle later.
REQ-034 With GATE_MUX_UNIT_CNT_EN defined, 65537 in_valid=1 cycles -> result_cnt=1.
